// File: rtl/req_ack_latency_monitor.sv
// Multi-channel req/ack latency monitor: measures req-rise to ack-rise
// cycles per channel and flags early, timeout, spurious and overlap events.
module req_ack_latency_monitor #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 8,
    parameter int LAT_MIN = 5,
    parameter int LAT_MAX = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       req,
    input  logic [NUM_CH-1:0]       ack,
    input  logic                    err_clr,
    output logic [NUM_CH-1:0]       done,
    output logic [NUM_CH-1:0]       ok,
    output logic [NUM_CH*CNT_W-1:0] lat,
    output logic [NUM_CH-1:0]       err_early,
    output logic [NUM_CH-1:0]       err_timeout,
    output logic [NUM_CH-1:0]       err_spurious,
    output logic [NUM_CH-1:0]       err_overlap,
    output logic [NUM_CH-1:0]       err_sticky
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        LATE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(LAT_MIN);
    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(LAT_MAX);

    state_t                        state_q [NUM_CH];
    state_t                        state_d [NUM_CH];
    logic [NUM_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [NUM_CH-1:0][CNT_W-1:0]  lat_q, lat_d;
    logic [NUM_CH-1:0]             req_q, req_d, ack_q, ack_d;
    logic [NUM_CH-1:0]             done_q, done_d, ok_q, ok_d;
    logic [NUM_CH-1:0]             early_q, early_d, tout_q, tout_d;
    logic [NUM_CH-1:0]             spur_q, spur_d, ovl_q, ovl_d;
    logic [NUM_CH-1:0]             sticky_q, sticky_d;
    logic [NUM_CH-1:0]             req_rise, ack_rise;

    assign req_rise = req & ~req_q;
    assign ack_rise = ack & ~ack_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_inc
        assign cnt_inc[g] = cnt_q[g] + CNT_W'(1);
    end

    always_comb begin
        req_d    = req;
        ack_d    = ack;
        cnt_d    = cnt_q;
        lat_d    = lat_q;
        done_d   = '0;
        ok_d     = '0;
        early_d  = '0;
        tout_d   = '0;
        spur_d   = '0;
        ovl_d    = '0;
        sticky_d = err_clr ? '0 : sticky_q;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            unique case (state_q[i])
                IDLE: begin
                    spur_d[i] = ack_rise[i];
                    if (req_rise[i]) begin
                        state_d[i] = WAIT;
                        cnt_d[i]   = '0;
                    end
                end
                WAIT: begin
                    if (ack_rise[i]) begin
                        lat_d[i]   = cnt_inc[i];
                        done_d[i]  = 1'b1;
                        ok_d[i]    = (cnt_inc[i] >= MIN_C) &&
                                     (cnt_inc[i] <= MAX_C);
                        early_d[i] = (cnt_inc[i] < MIN_C);
                        // A same-edge req rise opens the next transaction
                        state_d[i] = req_rise[i] ? WAIT : IDLE;
                        cnt_d[i]   = '0;
                    end else begin
                        ovl_d[i] = req_rise[i];
                        if (cnt_q[i] == MAX_C) begin
                            tout_d[i]  = 1'b1;
                            state_d[i] = LATE;
                        end else if (cnt_q[i] != CNT_SAT) begin
                            cnt_d[i] = cnt_inc[i];
                        end
                    end
                end
                LATE: begin
                    if (ack_rise[i]) begin
                        state_d[i] = req_rise[i] ? WAIT : IDLE;
                        cnt_d[i]   = '0;
                    end else begin
                        ovl_d[i] = req_rise[i];
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                end
            endcase
        end
        // Set wins over a same-edge clear
        sticky_d = sticky_d | early_d | tout_d | spur_d | ovl_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= IDLE;
            end
            cnt_q    <= '0;
            lat_q    <= '0;
            req_q    <= '0;
            ack_q    <= '0;
            done_q   <= '0;
            ok_q     <= '0;
            early_q  <= '0;
            tout_q   <= '0;
            spur_q   <= '0;
            ovl_q    <= '0;
            sticky_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lat_q    <= lat_d;
            req_q    <= req_d;
            ack_q    <= ack_d;
            done_q   <= done_d;
            ok_q     <= ok_d;
            early_q  <= early_d;
            tout_q   <= tout_d;
            spur_q   <= spur_d;
            ovl_q    <= ovl_d;
            sticky_q <= sticky_d;
        end
    end

    assign done         = done_q;
    assign ok           = ok_q;
    assign lat          = lat_q;
    assign err_early    = early_q;
    assign err_timeout  = tout_q;
    assign err_spurious = spur_q;
    assign err_overlap  = ovl_q;
    assign err_sticky   = sticky_q;

endmodule

// File: tb/tb_req_ack_latency_monitor.sv
// Bench for req_ack_latency_monitor: single-channel 5/5 and four-channel 4..6
// instances, events scored against a queue of expected pulses.
module tb_req_ack_latency_monitor;

    localparam logic [5:0] K_DONE = 6'b100000;
    localparam logic [5:0] K_OK   = 6'b010000;
    localparam logic [5:0] K_ERL  = 6'b001000;
    localparam logic [5:0] K_TO   = 6'b000100;
    localparam logic [5:0] K_SP   = 6'b000010;
    localparam logic [5:0] K_OV   = 6'b000001;

    typedef struct {
        int         edge_n;
        logic [5:0] kind;
        logic [7:0] lat;
    } ev_t;

    logic clk;
    int   cyc;
    int   checks;
    int   errors;
    ev_t  evq [5][$];

    logic       rst1_n, clr1;
    logic [0:0] r1, a1, done1, ok1, erl1, to1, sp1, ov1, st1;
    logic [7:0] lat1;

    logic        rst4_n, clr4;
    logic [3:0]  r4, a4, done4, ok4, erl4, to4, sp4, ov4, st4;
    logic [31:0] lat4;

    req_ack_latency_monitor #(
        .NUM_CH(1), .CNT_W(8), .LAT_MIN(5), .LAT_MAX(5)
    ) u_dut1 (
        .clk(clk), .rst_n(rst1_n), .req(r1), .ack(a1), .err_clr(clr1),
        .done(done1), .ok(ok1), .lat(lat1), .err_early(erl1),
        .err_timeout(to1), .err_spurious(sp1), .err_overlap(ov1),
        .err_sticky(st1)
    );

    req_ack_latency_monitor #(
        .NUM_CH(4), .CNT_W(8), .LAT_MIN(4), .LAT_MAX(6)
    ) u_dut4 (
        .clk(clk), .rst_n(rst4_n), .req(r4), .ack(a4), .err_clr(clr4),
        .done(done4), .ok(ok4), .lat(lat4), .err_early(erl4),
        .err_timeout(to4), .err_spurious(sp4), .err_overlap(ov4),
        .err_sticky(st4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int qi, input int e, input logic [5:0] k,
                        input logic [7:0] l);
        evq[qi].push_back('{e, k, l});
    endtask

    task automatic mon(input int qi, input logic [5:0] got,
                       input logic [7:0] glat);
        ev_t ev;
        if (evq[qi].size() > 0) begin
            checks++;
            assert (evq[qi][0].edge_n >= cyc) else begin
                errors++;
                $error("FAIL missed q%0d obs=none exp=%b@%0d",
                       qi, evq[qi][0].kind, evq[qi][0].edge_n);
                void'(evq[qi].pop_front());
            end
        end
        if (got != '0) begin
            checks++;
            assert (evq[qi].size() > 0) else begin
                errors++;
                $error("FAIL unexp q%0d obs=%b@%0d exp=none", qi, got, cyc);
            end
            if (evq[qi].size() > 0) begin
                ev = evq[qi].pop_front();
                checks++;
                assert (cyc === ev.edge_n) else begin
                    errors++;
                    $error("FAIL edge q%0d obs=%0d exp=%0d",
                           qi, cyc, ev.edge_n);
                end
                checks++;
                assert (got === ev.kind) else begin
                    errors++;
                    $error("FAIL kind q%0d obs=%b exp=%b", qi, got, ev.kind);
                end
                if (ev.kind[5]) begin
                    checks++;
                    assert (glat === ev.lat) else begin
                        errors++;
                        $error("FAIL lat q%0d obs=%0d exp=%0d",
                               qi, glat, ev.lat);
                    end
                end
            end
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        #1;
        mon(0, {done1[0], ok1[0], erl1[0], to1[0], sp1[0], ov1[0]}, lat1);
        for (int c = 0; c < 4; c++) begin
            mon(c + 1, {done4[c], ok4[c], erl4[c], to4[c], sp4[c], ov4[c]},
                lat4[c*8 +: 8]);
        end
    end

    task automatic txn1(input int d, input logic [5:0] k);
        int e0;
        @(negedge clk);
        r1 = 1'b1;
        e0 = cyc + 1;
        repeat (d) @(negedge clk);
        a1 = 1'b1;
        push(0, e0 + d, k, 8'(d));
        @(negedge clk);
        r1 = 1'b0;
        a1 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic burst4(input int d0, input int d1, input int d2,
                          input int d3);
        int d [4];
        int e0;
        d = '{d0, d1, d2, d3};
        @(negedge clk);
        r4 = 4'hF;
        e0 = cyc + 1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                if (d[c] == k) begin
                    a4[c] = 1'b1;
                    push(c + 1, e0 + k,
                         (k < 4) ? (K_DONE | K_ERL) : (K_DONE | K_OK),
                         8'(k));
                end
            end
        end
        @(negedge clk);
        r4 = '0;
        a4 = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int e0;
        int e1;
        cyc    = 0;
        checks = 0;
        errors = 0;
        rst1_n = 1'b0;
        rst4_n = 1'b0;
        clr1   = 1'b0;
        clr4   = 1'b0;
        r1     = '0;
        a1     = '0;
        r4     = '0;
        a4     = '0;
        repeat (3) @(negedge clk);
        chk("rst1_pulses", {done1, ok1, erl1, to1, sp1, ov1}, 0);
        chk("rst1_lat", lat1, 0);
        chk("rst1_sticky", st1, 0);
        chk("rst4_done", done4, 0);
        chk("rst4_lat", lat4, 0);
        chk("rst4_sticky", st4, 0);
        rst1_n = 1'b1;
        rst4_n = 1'b1;
        repeat (2) @(negedge clk);

        // nominal latency, repeated
        repeat (5) txn1(5, K_DONE | K_OK);
        chk("ok_sticky", st1, 0);
        chk("ok_lat", lat1, 5);

        // early completion, then clear
        txn1(3, K_DONE | K_ERL);
        chk("early_sticky", st1, 1);
        chk("early_lat", lat1, 3);
        @(negedge clk);
        clr1 = 1'b1;
        @(negedge clk);
        clr1 = 1'b0;
        chk("clr_sticky", st1, 0);

        // timeout, late ack is silent, then a good transaction
        @(negedge clk);
        r1 = 1'b1;
        e0 = cyc + 1;
        push(0, e0 + 6, K_TO, 8'd0);
        repeat (8) @(negedge clk);
        a1 = 1'b1;
        @(negedge clk);
        r1 = 1'b0;
        a1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("to_lat_hold", lat1, 3);
        txn1(5, K_DONE | K_OK);
        chk("to_sticky", st1, 1);

        // spurious ack, then overlap while waiting
        @(negedge clk);
        a1 = 1'b1;
        push(0, cyc + 1, K_SP, 8'd0);
        @(negedge clk);
        a1 = 1'b0;
        @(negedge clk);
        r1 = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        r1 = 1'b0;
        @(negedge clk);
        r1 = 1'b1;
        push(0, e0 + 2, K_OV, 8'd0);
        repeat (3) @(negedge clk);
        a1 = 1'b1;
        push(0, e0 + 5, K_DONE | K_OK, 8'd5);
        @(negedge clk);
        r1 = 1'b0;
        a1 = 1'b0;
        repeat (2) @(negedge clk);

        // reset mid-wait at cnt=2
        @(negedge clk);
        r1 = 1'b1;
        repeat (3) @(negedge clk);
        rst1_n = 1'b0;
        #1;
        chk("midrst_sticky", st1, 0);
        chk("midrst_lat", lat1, 0);
        chk("midrst_pulses", {done1, ok1, erl1, to1, sp1, ov1}, 0);
        r1 = 1'b0;
        @(negedge clk);
        rst1_n = 1'b1;
        @(negedge clk);
        a1 = 1'b1;
        push(0, cyc + 1, K_SP, 8'd0);
        @(negedge clk);
        a1 = 1'b0;
        repeat (3) @(negedge clk);

        // four concurrent channels, window edges and random latencies
        burst4(4, 6, $urandom_range(6, 4), $urandom_range(6, 4));
        burst4($urandom_range(6, 4), $urandom_range(6, 4),
               $urandom_range(6, 4), $urandom_range(6, 4));
        chk("ch4_sticky_ok", st4, 0);

        // ack and new req on the same edge: no overlap
        @(negedge clk);
        r4 = 4'hF;
        e0 = cyc + 1;
        @(negedge clk);
        r4 = '0;
        repeat (4) @(negedge clk);
        r4 = 4'hF;
        a4 = 4'hF;
        e1 = e0 + 5;
        for (int c = 1; c <= 4; c++) push(c, e1, K_DONE | K_OK, 8'd5);
        @(negedge clk);
        a4 = '0;
        repeat (3) @(negedge clk);
        a4 = 4'hF;
        for (int c = 1; c <= 4; c++) push(c, e1 + 4, K_DONE | K_OK, 8'd4);
        @(negedge clk);
        r4 = '0;
        a4 = '0;
        repeat (2) @(negedge clk);
        chk("b2b_sticky", st4, 0);
        chk("b2b_lat", lat4, 32'h04040404);

        // early on channel 0 only
        burst4(3, 5, 4, 6);
        chk("ch4_sticky_early", st4, 4'b0001);

        repeat (10) @(negedge clk);
        for (int i = 0; i < 5; i++) chk("q_empty", evq[i].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
